mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Shares one sequential multiplier datapath (start/valid-controlled, variable-shift Booth core) between two independent requesters. Grants access round-robin, latches the winner's operands, pulses the multiplier start, waits for the multiplier's valid, and returns the product to the granted requester with a one-cycle done strobe. Sits between the two client blocks and the multiplier top level; the only block that drives the multiplier's start and operand inputs.

## Interface

- WIDTH, 8: operand width; product is 2*WIDTH.
- TIMEOUT, 32: max WAIT cycles before abort; used only when MULT_ARB_TIMEOUT_EN is defined.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- req  in  2  request per requester; level, held with operands stable until matching done bit.
- a0, b0  in  WIDTH  requester 0 operands, two's complement.
- a1, b1  in  WIDTH  requester 1 operands.
- done  out  2  one-cycle strobe to the served requester; one-hot or zero.
- result  out  2*WIDTH  product, valid when any done bit is high.
- err  out  1  high with done when the operation was aborted by timeout.
- busy  out  1  high in every state except IDLE.
- m_start  out  1  one-cycle start pulse to multiplier.
- m_a, m_b  out  WIDTH  operands to multiplier, held from ISSUE through WAIT.
- m_valid  in  1  multiplier valid level.
- m_prod  in  2*WIDTH  multiplier product.

## Operation

- States: IDLE, ISSUE, WAIT, DONE (2-bit encoded).
- IDLE: if no req, stay. If one req bit set, grant it. If both set, grant the requester not served last (last pointer). Latch winner's a/b into m_a/m_b, record grant index, go ISSUE.
- ISSUE: m_start=1 for exactly this cycle; go WAIT.
- WAIT: m_start=0; m_valid sampled only here. On m_valid=1: register m_prod into result, go DONE.
- DONE: done[grant]=1 for this cycle, err as computed, last pointer <= grant; go IDLE.
- Requests are re-evaluated only in IDLE. A requester keeping req high after its done issues a new operation; round-robin still applies, so with both high, grants alternate 0,1,0,1.
- Operand changes while req is high are not captured after IDLE; arbiter never modifies operand values (pure pass-through; sign handling is the multiplier's).
- result holds its last value between operations; it is meaningful only with a done bit.

## Timing

- Reset (async, any state): state=IDLE, done=0, err=0, busy=0, m_start=0, m_a=m_b=0, result=0, last pointer=1 (requester 0 wins first contention). In-flight multiplier work is abandoned; the next m_start reloads the multiplier.
- Latency from req sampled high in IDLE to done: 1 (IDLE->ISSUE) + 1 (ISSUE) + L (multiplier cycles until m_valid) + 1 (DONE); minimum 4 cycles with L=1.
- m_valid stale from a previous operation is never observed: start clears it at the ISSUE edge, and WAIT begins the cycle after.
- Throughput: one operation per L+3 cycles; one IDLE cycle between consecutive operations.
- req deasserted mid-operation: operation completes, done still pulses; requester ignores it.
- Simultaneous new req and DONE: new req waits for IDLE.

## Configuration

- MULT_ARB_TIMEOUT_EN defined: WAIT counts cycles from 0; if count reaches TIMEOUT-1 with m_valid low, go DONE with result=0, err=1. Counter clears on entering WAIT.
- Undefined: no counter, WAIT waits indefinitely, err tied to 0.

## Test plan

- Reset, req=2'b01, a0=3, b0=5 -> m_start one cycle after grant, done=2'b01, result=16'd15, err=0, busy low next cycle.
- req0 with a0=-3 (8'hFD), b0=5 -> result=16'hFFF1, done=2'b01.
- After reset, req=2'b11, a0=7,b0=9, a1=12,b1=12 -> done=2'b01 result=63 first, then done=2'b10 result=144; held high for four ops -> grant order 0,1,0,1.
- Assert rst_n low during WAIT -> all outputs zero immediately, no done; after release, req1 6*7 -> done=2'b10, result=42.
- Stub multiplier with fixed L=1 -> req to done exactly 4 cycles, back-to-back ops every 4 cycles plus one IDLE.
- With MULT_ARB_TIMEOUT_EN, TIMEOUT=32, m_valid stuck low -> done after 32 WAIT cycles, err=1, result=0; without macro, busy stays high, no done.

Source files
------------

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one sequential multiplier between two requesters
//
// Two requesters raise req and hold their operands stable. The arbiter grants one
// of them (round-robin on contention), latches its operands onto m_a/m_b, pulses
// m_start for one cycle, waits for m_valid and hands the product back with a
// one-cycle done strobe on the served requester's bit.
//
// Optional feature macro: MULT_ARB_TIMEOUT_EN
//   defined   - WAIT is bounded to TIMEOUT cycles; on expiry the operation ends
//               with result=0 and err=1.
//   undefined - WAIT lasts until m_valid; err is tied low.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [1:0] request level per requester
//   a0, b0   in   [WIDTH-1:0] requester 0 operands
//   a1, b1   in   [WIDTH-1:0] requester 1 operands
//   done     out  [1:0] one-cycle completion strobe, one-hot or zero
//   result   out  [2*WIDTH-1:0] product, meaningful while a done bit is high
//   err      out  high with done when the operation timed out
//   busy     out  high in every state except IDLE
//   m_start  out  one-cycle start pulse to the multiplier
//   m_a, m_b out  [WIDTH-1:0] operands to the multiplier
//   m_valid  in   multiplier product valid level
//   m_prod   in   [2*WIDTH-1:0] multiplier product

module mult_arbiter #(
    parameter int WIDTH   = 8
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic [1:0]           done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic                 m_start,
    output logic [WIDTH-1:0]     m_a,
    output logic [WIDTH-1:0]     m_b,
    input  logic                 m_valid,
    input  logic [2*WIDTH-1:0]   m_prod
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state_q,  state_d;
    logic                 grant_q,  grant_d;
    logic                 last_q,   last_d;
    logic [WIDTH-1:0]     m_a_q,    m_a_d;
    logic [WIDTH-1:0]     m_b_q,    m_b_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0]        cnt_q,    cnt_d;
    logic                 err_q,    err_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;   // requester 0 wins the first contention
            m_a_q    <= '0;
            m_b_q    <= '0;
            result_q <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            m_a_q    <= m_a_d;
            m_b_q    <= m_b_d;
            result_q <= result_d;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        logic winner;
        winner   = 1'b0;
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        m_a_d    = m_a_q;
        m_b_d    = m_b_q;
        result_d = result_q;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // On contention serve whoever was not served last;
                    // otherwise serve the single requester.
                    winner  = (req == 2'b11) ? ~last_q : req[1];
                    grant_d = winner;
                    m_a_d   = winner ? a1 : a0;
                    m_b_d   = winner ? b1 : b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_valid) begin
                    result_d = m_prod;
                    state_d  = S_DONE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                end
`endif
            end
            default: begin   // S_DONE
                last_d  = grant_q;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        done    = 2'b00;
        err     = 1'b0;
        busy    = (state_q != S_IDLE);
        m_start = (state_q == S_ISSUE);
        if (state_q == S_DONE) begin
            done = grant_q ? 2'b10 : 2'b01;
`ifdef MULT_ARB_TIMEOUT_EN
            err  = err_q;
`endif
        end
    end

    assign m_a    = m_a_q;
    assign m_b    = m_b_q;
    assign result = result_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter with a latency-configurable multiplier stub

module tb_mult_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req;
    logic [W-1:0]   a0, b0, a1, b1;
    logic [1:0]     done;
    logic [2*W-1:0] result;
    logic           err;
    logic           busy;
    logic           m_start;
    logic [W-1:0]   m_a, m_b;
    logic           m_valid = 1'b0;
    logic [2*W-1:0] m_prod  = '0;

    int checks = 0;
    int errors = 0;
    int model_last = 1;     // reference round-robin pointer
    int stub_lat = 1;       // multiplier cycles until m_valid
    bit stub_stuck = 1'b0;  // multiplier never raises m_valid
    int stub_cnt = 0;

    mult_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done(done), .result(result), .err(err), .busy(busy),
        .m_start(m_start), .m_a(m_a), .m_b(m_b),
        .m_valid(m_valid), .m_prod(m_prod)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx, sy;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        return sx * sy;
    endfunction

    // Multiplier stub: start clears valid; valid rises stub_lat cycles after the start edge.
    always @(posedge clk) begin
        if (m_start) begin
            stub_cnt <= stub_lat - 1;
            m_prod   <= smul(m_a, m_b);
            m_valid  <= (!stub_stuck && stub_lat == 1);
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_stuck) m_valid <= 1'b1;
        end
    end

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return (model_last == 1) ? 0 : 1;
        return r[1] ? 1 : 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
    endtask

    // Waits (bounded) for a done strobe, sampling on negedges. n counts negedges
    // from the call; n = -1 when the budget expires.
    task automatic wait_done(input int budget, input bit scramble,
                             output logic [1:0] d, output logic [2*W-1:0] r, output logic e,
                             output int n, output int st_n, output int st_cnt);
        d = 2'b00; r = '0; e = 1'b0; n = -1; st_n = -1; st_cnt = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (scramble && i == 1) begin
                a0 = W'($urandom); b0 = W'($urandom);
                a1 = W'($urandom); b1 = W'($urandom);
            end
            if (m_start) begin
                st_cnt++;
                st_n = i;
            end
            if (done != 2'b00) begin
                d = done; r = result; e = err; n = i;
                break;
            end
        end
    endtask

    // One complete operation: done arrives in the 4th cycle for L=1, i.e. after
    // 2+L edges counted from the request cycle.
    task automatic run_op(input logic [1:0] r, input bit scramble, output logic [2*W-1:0] got);
        int w, n, st_n, st_cnt;
        logic [2*W-1:0] exp_p;
        logic [1:0] d;
        logic e;
        w = pick(r);
        exp_p = (w == 1) ? smul(a1, b1) : smul(a0, b0);
        req = r;
        wait_done(60, scramble, d, got, e, n, st_n, st_cnt);
        req = 2'b00;
        checks++;
        if (d !== 2'(1 << w)) begin
            errors++;
            $display("FAIL op_done req=%b got %b expected %b", r, d, 2'(1 << w));
        end
        checks++;
        if (got !== exp_p) begin
            errors++;
            $display("FAIL op_result got %h expected %h", got, exp_p);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL op_err got %b expected 0", e);
        end
        checks++;
        if (n != 2 + stub_lat) begin
            errors++;
            $display("FAIL op_latency got %0d expected %0d", n, 2 + stub_lat);
        end
        checks++;
        if (st_cnt != 1 || st_n != 1) begin
            errors++;
            $display("FAIL op_start pulses %0d at %0d expected 1 at 1", st_cnt, st_n);
        end
        model_last = w;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL op_idle busy got %b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b00;
        a0 = 8'h5A; b0 = 8'hA5; a1 = 8'h33; b1 = 8'hCC;
        #1;
        checks++;
        if ({done, err, busy, m_start} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 00000", {done, err, busy, m_start});
        end
        checks++;
        if ({m_a, m_b} !== '0) begin
            errors++;
            $display("FAIL reset_operands got %h expected 0", {m_a, m_b});
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result got %h expected 0", result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
    endtask

    task automatic test_single();
        logic [2*W-1:0] got;
        stub_lat = 1;
        a0 = 8'd3; b0 = 8'd5;
        run_op(2'b01, 1'b0, got);
        checks++;
        if (got !== 16'd15) begin
            errors++;
            $display("FAIL single_3x5 got %h expected 000f", got);
        end
        a0 = 8'hFD; b0 = 8'd5;
        run_op(2'b01, 1'b0, got);
        checks++;
        if (got !== 16'hFFF1) begin
            errors++;
            $display("FAIL single_neg3x5 got %h expected fff1", got);
        end
    endtask

    task automatic test_contention();
        logic [1:0] d;
        logic [2*W-1:0] r;
        logic e;
        int n, st_n, st_cnt, w;
        logic [2*W-1:0] exp_p;
        do_reset();
        stub_lat = 2;
        a0 = 8'd7; b0 = 8'd9; a1 = 8'd12; b1 = 8'd12;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = pick(2'b11);
            exp_p = (w == 1) ? 16'd144 : 16'd63;
            wait_done(60, 1'b0, d, r, e, n, st_n, st_cnt);
            checks++;
            if (d !== 2'(1 << w) || r !== exp_p) begin
                errors++;
                $display("FAIL contention_%0d got done=%b result=%0d expected done=%b result=%0d",
                         k, d, r, 2'(1 << w), exp_p);
            end
            checks++;
            if (d !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL contention_order_%0d got %b expected %b", k, d,
                         (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            model_last = w;
        end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        logic [2*W-1:0] got;
        int seen;
        stub_lat = 12;
        a0 = 8'd10; b0 = 8'd10;
        req = 2'b01;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 2'b00) begin
            errors++;
            $display("FAIL rst_wait_pre busy=%b done=%b expected busy=1 done=00", busy, done);
        end
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        checks++;
        if ({done, err, busy, m_start, m_a, m_b, result} !== '0) begin
            errors++;
            $display("FAIL rst_wait_outputs got %h expected 0",
                     {done, err, busy, m_start, m_a, m_b, result});
        end
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done != 2'b00) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_wait_nodone got %0d strobes expected 0", seen);
        end
        model_last = 1;
        stub_lat = 2;
        a1 = 8'd6; b1 = 8'd7;
        run_op(2'b10, 1'b0, got);
        checks++;
        if (got !== 16'd42) begin
            errors++;
            $display("FAIL rst_wait_recover got %0d expected 42", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] d;
        logic [2*W-1:0] r;
        logic e;
        int n, st_n, st_cnt;
        stub_lat = 1;
        a0 = 8'd2; b0 = 8'd11;
        req = 2'b01;
        for (int k = 0; k < 3; k++) begin
            wait_done(30, 1'b0, d, r, e, n, st_n, st_cnt);
            checks++;
            // first: done in 4th cycle (3 edges); then one op every L+3 cycles
            if (n != ((k == 0) ? 3 : 4) || d !== 2'b01 || r !== 16'd22) begin
                errors++;
                $display("FAIL b2b_%0d got gap=%0d done=%b result=%0d expected gap=%0d done=01 result=22",
                         k, n, d, r, (k == 0) ? 3 : 4);
            end
        end
        req = 2'b00;
        model_last = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [2*W-1:0] got;
        for (int k = 0; k < 40; k++) begin
            stub_lat = $urandom_range(1, 5);
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
            run_op(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), got);
        end
    endtask

    task automatic test_stall();
        logic [1:0] d;
        logic [2*W-1:0] r;
        logic e;
        int n, st_n, st_cnt;
        stub_stuck = 1'b1;
        stub_lat = 1;
        a0 = 8'd5; b0 = 8'd5;
        req = 2'b01;
        wait_done(80, 1'b0, d, r, e, n, st_n, st_cnt);
`ifdef MULT_ARB_TIMEOUT_EN
        checks++;
        if (n != 2 + 32 || d !== 2'b01 || e !== 1'b1 || r !== '0) begin
            errors++;
            $display("FAIL stall_timeout got n=%0d done=%b err=%b result=%h expected n=34 done=01 err=1 result=0",
                     n, d, e, r);
        end
        req = 2'b00;
        model_last = 0;
        stub_stuck = 1'b0;
        repeat (2) @(negedge clk);
`else
        checks++;
        if (n != -1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got done_at=%0d busy=%b expected none busy=1", n, busy);
        end
        req = 2'b00;
        stub_stuck = 1'b0;
        do_reset();
`endif
    endtask

    initial begin
        rst_n = 1'b1;
        req = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_contention();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
